// File: rtl/rf_pkg.sv
// Shared register-file definitions: geometry and the writeback queue entry layout.
package rf_pkg;
   localparam int RF_DATA_W = 8;
   localparam int RF_ADDR_W = 2;
   localparam int RF_NREGS  = 4;

   typedef struct packed {
      logic                 valid;
      logic [RF_ADDR_W-1:0] rd;
      logic [RF_DATA_W-1:0] data;
   } rf_wb_entry_t;
endpackage

// File: rtl/rf_writeback_if.sv
// Writeback front-end bus: result push, regfile write port, decode forwarding queries.
interface rf_writeback_if #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic [ADDR_W-1:0]       in_rd;
   logic [DATA_W-1:0]       in_data;
   logic                    hold;
   logic                    rf_we;
   logic [ADDR_W-1:0]       rf_rd;
   logic [DATA_W-1:0]       rf_wd;
   logic [ADDR_W-1:0]       q_rs1;
   logic [ADDR_W-1:0]       q_rs2;
   logic                    q_hit1;
   logic                    q_hit2;
   logic [DATA_W-1:0]       q_data1;
   logic [DATA_W-1:0]       q_data2;
   logic [(1<<ADDR_W)-1:0]  pending;

   modport master (
      output in_valid, in_rd, in_data, hold, q_rs1, q_rs2,
      input  in_ready, rf_we, rf_rd, rf_wd, q_hit1, q_hit2, q_data1, q_data2, pending
   );

   modport slave (
      input  in_valid, in_rd, in_data, hold, q_rs1, q_rs2,
      output in_ready, rf_we, rf_rd, rf_wd, q_hit1, q_hit2, q_data1, q_data2, pending
   );
endinterface

// File: rtl/rf_wb_fifo.sv
// In-order circular queue of writeback entries; the whole entry array is exposed
// so the parent can run forwarding and pending logic against it.
module rf_wb_fifo
   import rf_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int CNT_W = PTR_W + 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [RF_ADDR_W-1:0]     push_rd,
   input  logic [RF_DATA_W-1:0]     push_data,
   output rf_wb_entry_t [DEPTH-1:0] entries,
   output logic [PTR_W-1:0]         rd_ptr,
   output logic [PTR_W-1:0]         wr_ptr,
   output logic [CNT_W-1:0]         count,
   output logic                     full,
   output logic                     empty
);
   rf_wb_entry_t [DEPTH-1:0] ent_q, ent_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]         count_q, count_d;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   // Push is only legal when not full, so it never lands on the slot being popped.
   always_comb begin
      ent_d    = ent_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (pop && !empty) begin
         ent_d[rd_ptr_q].valid = 1'b0;
         rd_ptr_d              = rd_ptr_q + 1'b1;
      end
      if (push && !full) begin
         ent_d[wr_ptr_q] = '{valid: 1'b1, rd: push_rd, data: push_data};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push && !full) - CNT_W'(pop && !empty);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ent_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         ent_q    <= ent_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign entries = ent_q;
   assign rd_ptr  = rd_ptr_q;
   assign wr_ptr  = wr_ptr_q;
   assign count   = count_q;
endmodule

// File: rtl/rf_writeback.sv
// Regfile write-side front end: drains queued results one per cycle and forwards
// not-yet-written values to decode's two read ports.
module rf_writeback
   import rf_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W
) (
   input logic           clk,
   input logic           reset_n,
   rf_writeback_if.slave wb
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   rf_wb_entry_t [DEPTH-1:0] ent;
   logic [PTR_W-1:0]         rd_ptr, wr_ptr;
   logic [CNT_W-1:0]         count;
   logic                     full, empty, push, pop;
   logic [1:0][ADDR_W-1:0]   rs;
   logic [1:0]               hit;
   logic [1:0][DATA_W-1:0]   fwd;
   logic [(1<<ADDR_W)-1:0]   pend;

   assign push = wb.in_valid & ~full;
   assign pop  = ~empty & ~wb.hold;

   rf_wb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .pop       (pop),
      .push_rd   (wb.in_rd),
      .push_data (wb.in_data),
      .entries   (ent),
      .rd_ptr    (rd_ptr),
      .wr_ptr    (wr_ptr),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   assign wb.in_ready = ~full;
   assign wb.rf_we    = pop;
   assign wb.rf_rd    = empty ? '0 : ent[rd_ptr].rd;
   assign wb.rf_wd    = empty ? '0 : ent[rd_ptr].data;

   assign rs[0] = wb.q_rs1;
   assign rs[1] = wb.q_rs2;

   // Walk oldest to youngest so the last match (closest to wr_ptr) supplies the data.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx = '0;
      hit = '0;
      fwd = '0;
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (ent[idx].valid && (ent[idx].rd == rs[p])) begin
               hit[p] = 1'b1;
               fwd[p] = ent[idx].data;
            end
         end
      end
   end

   assign wb.q_hit1  = hit[0];
   assign wb.q_hit2  = hit[1];
   assign wb.q_data1 = fwd[0];
   assign wb.q_data2 = fwd[1];

   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent[i].valid) pend[ent[i].rd] = 1'b1;
      end
   end

   assign wb.pending = pend;
endmodule

// File: tb/tb_rf_writeback.sv
// Randomized and directed checks of rf_writeback against a queue-based reference model.
module tb_rf_writeback;
   import rf_pkg::*;

   localparam int DEPTH = 2;

   typedef struct {
      logic [1:0] rd;
      logic [7:0] d;
   } m_ent_t;

   logic   clk = 1'b0;
   logic   reset_n = 1'b0;
   int     n_cmp = 0;
   int     n_err = 0;
   m_ent_t mq[$];
   logic [7:0] rf_m   [4];
   logic [7:0] rf_dut [4];

   always #5 clk = ~clk;

   rf_writeback_if #(.ADDR_W(2), .DATA_W(8)) bus ();

   rf_writeback #(.DEPTH(DEPTH), .DATA_W(8), .ADDR_W(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .wb      (bus)
   );

   // Behavioural regfile fed by the DUT's write port.
   always @(posedge clk) begin
      if (bus.rf_we === 1'b1) rf_dut[bus.rf_rd] <= bus.rf_wd;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void fwd_m(input logic [1:0] rs, output bit hit, output logic [7:0] d);
      hit = 1'b0;
      d   = 8'h00;
      for (int i = mq.size() - 1; i >= 0; i--) begin
         if (mq[i].rd == rs) begin
            hit = 1'b1;
            d   = mq[i].d;
            break;
         end
      end
   endfunction

   task automatic step(input bit iv, input logic [1:0] rd, input logic [7:0] d,
                       input bit h, input logic [1:0] r1, input logic [1:0] r2);
      bit         e_rdy, e_we, e_h1, e_h2;
      logic [1:0] e_rd;
      logic [7:0] e_wd, e_d1, e_d2;
      logic [3:0] e_pend;
      @(negedge clk);
      bus.in_valid = iv;
      bus.in_rd    = rd;
      bus.in_data  = d;
      bus.hold     = h;
      bus.q_rs1    = r1;
      bus.q_rs2    = r2;
      #1;
      e_rdy  = (mq.size() < DEPTH);
      e_we   = (mq.size() != 0) && !h;
      e_rd   = (mq.size() != 0) ? mq[0].rd : 2'd0;
      e_wd   = (mq.size() != 0) ? mq[0].d  : 8'd0;
      e_pend = '0;
      foreach (mq[i]) e_pend[mq[i].rd] = 1'b1;
      fwd_m(r1, e_h1, e_d1);
      fwd_m(r2, e_h2, e_d2);
      chk("in_ready", 32'(bus.in_ready), 32'(e_rdy));
      chk("rf_we",    32'(bus.rf_we),    32'(e_we));
      chk("rf_rd",    32'(bus.rf_rd),    32'(e_rd));
      chk("rf_wd",    32'(bus.rf_wd),    32'(e_wd));
      chk("pending",  32'(bus.pending),  32'(e_pend));
      chk("q_hit1",   32'(bus.q_hit1),   32'(e_h1));
      chk("q_data1",  32'(bus.q_data1),  32'(e_d1));
      chk("q_hit2",   32'(bus.q_hit2),   32'(e_h2));
      chk("q_data2",  32'(bus.q_data2),  32'(e_d2));
      chk("regfile",  32'(rf_dut[r1]),   32'(rf_m[r1]));
      @(posedge clk);
      if (e_we) begin
         rf_m[mq[0].rd] = mq[0].d;
         void'(mq.pop_front());
      end
      if (iv && e_rdy) mq.push_back('{rd: rd, d: d});
   endtask

   // Reset asserted mid-cycle: outputs must drop at once and queued entries vanish.
   task automatic mid_reset();
      @(negedge clk);
      bus.in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_rf_we",   32'(bus.rf_we),   32'd0);
      chk("rst_rf_rd",   32'(bus.rf_rd),   32'd0);
      chk("rst_rf_wd",   32'(bus.rf_wd),   32'd0);
      chk("rst_pending", 32'(bus.pending), 32'd0);
      chk("rst_q_hit1",  32'(bus.q_hit1),  32'd0);
      chk("rst_q_hit2",  32'(bus.q_hit2),  32'd0);
      chk("rst_q_data1", 32'(bus.q_data1), 32'd0);
      chk("rst_ready",   32'(bus.in_ready), 32'd1);
      mq.delete();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         rf_m[i]   = 8'h00;
         rf_dut[i] = 8'h00;
      end
      bus.in_valid = 1'b0;
      bus.in_rd    = '0;
      bus.in_data  = '0;
      bus.hold     = 1'b0;
      bus.q_rs1    = '0;
      bus.q_rs2    = '0;
      #1;
      chk("init_rf_we",   32'(bus.rf_we),    32'd0);
      chk("init_ready",   32'(bus.in_ready), 32'd1);
      chk("init_pending", 32'(bus.pending),  32'd0);
      #11;
      @(negedge clk);
      reset_n = 1'b1;

      // empty queue: no false hit
      step(0, 2'd0, 8'h00, 0, 2'd3, 2'd0);
      // single write
      step(1, 2'd2, 8'h5A, 0, 2'd2, 2'd2);
      step(0, 2'd0, 8'h00, 0, 2'd2, 2'd0);
      step(0, 2'd0, 8'h00, 0, 2'd2, 2'd0);
      // youngest-match forwarding
      step(1, 2'd1, 8'h11, 1, 2'd1, 2'd1);
      step(1, 2'd1, 8'h22, 1, 2'd1, 2'd1);
      step(0, 2'd0, 8'h00, 1, 2'd1, 2'd1);
      step(0, 2'd0, 8'h00, 0, 2'd1, 2'd1);
      step(0, 2'd0, 8'h00, 0, 2'd1, 2'd1);
      step(0, 2'd0, 8'h00, 0, 2'd1, 2'd2);
      // full / back-pressure
      step(1, 2'd0, 8'hA0, 1, 2'd0, 2'd3);
      step(1, 2'd3, 8'hA3, 1, 2'd0, 2'd3);
      step(1, 2'd2, 8'hB2, 1, 2'd2, 2'd3);
      step(1, 2'd2, 8'hB2, 0, 2'd2, 2'd0);
      step(1, 2'd2, 8'hB2, 0, 2'd2, 2'd3);
      step(0, 2'd0, 8'h00, 0, 2'd2, 2'd3);
      step(0, 2'd0, 8'h00, 0, 2'd2, 2'd0);
      step(0, 2'd0, 8'h00, 0, 2'd2, 2'd3);
      // simultaneous push/pop at count=1
      step(1, 2'd0, 8'h30, 0, 2'd0, 2'd1);
      for (int i = 0; i < 8; i++) step(1, 2'(i), 8'h40 + 8'(i), 0, 2'(i), 2'(i + 1));
      step(0, 2'd0, 8'h00, 0, 2'd3, 2'd0);
      step(0, 2'd0, 8'h00, 0, 2'd3, 2'd0);
      // reset with two entries queued
      step(1, 2'd3, 8'hC3, 1, 2'd3, 2'd1);
      step(1, 2'd1, 8'hC1, 1, 2'd3, 2'd1);
      mid_reset();
      step(0, 2'd0, 8'h00, 0, 2'd3, 2'd1);
      step(1, 2'd3, 8'hD3, 0, 2'd3, 2'd1);
      step(0, 2'd0, 8'h00, 0, 2'd3, 2'd1);

      // randomized traffic with occasional resets
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 199) == 0) mid_reset();
         else step(($urandom_range(0, 9) < 7), 2'($urandom), 8'($urandom),
                   ($urandom_range(0, 9) < 3), 2'($urandom), 2'($urandom));
      end
      step(0, 2'd0, 8'h00, 0, 2'd0, 2'd1);
      step(0, 2'd0, 8'h00, 0, 2'd2, 2'd3);
      step(0, 2'd0, 8'h00, 0, 2'd1, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
